// File: rtl/fgmt_fetch_scheduler.sv
// Per-thread PC file and round-robin thread picker for the interleaved-multithreading
// fetch stage, with enable/block masks, global stall and same-edge branch-redirect bypass.
module fgmt_fetch_scheduler #(
  parameter int                N_THREADS       = 4,
  parameter int                PC_WIDTH        = 32,
  parameter int                INSTR_BYTES     = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC_BASE   = '0,
  parameter logic [PC_WIDTH-1:0] RESET_PC_STRIDE = PC_WIDTH'('h100),
  localparam int               TID_W           = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_THREADS-1:0]            thread_en,
  input  logic [N_THREADS-1:0]            thread_block,
  input  logic                            fetch_stall,
  input  logic                            br_taken,
  input  logic [PC_WIDTH-1:0]             br_addr,
  input  logic [TID_W-1:0]                br_tid,
  output logic [PC_WIDTH-1:0]             pcf,
  output logic [TID_W-1:0]                tidf,
  output logic                            fetch_valid,
  output logic [N_THREADS*PC_WIDTH-1:0]   pc_t
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);

  logic [PC_WIDTH-1:0] r_pc_p0 [N_THREADS];
  logic [PC_WIDTH-1:0] r_pcf_p1;
  logic [TID_W-1:0]    r_tidf_p1;
  logic                r_vld_p1;
  logic [TID_W-1:0]    r_rr_ptr;

  logic [N_THREADS-1:0] w_elig;
  logic                 w_found;
  logic [TID_W-1:0]     w_pick;
  logic [TID_W-1:0]     w_idx;
  logic [PC_WIDTH-1:0]  w_pick_pc;
  logic                 w_br_vld;
  logic                 w_take;
  logic                 w_bypass;

  function automatic logic [PC_WIDTH-1:0] reset_pc(input int i);
    return RESET_PC_BASE + PC_WIDTH'(i) * RESET_PC_STRIDE;
  endfunction

  // A thread id beyond N_THREADS can only exist when the count is not a power of two.
  generate
    if ((1 << TID_W) == N_THREADS) begin : g_tid_full
      assign w_br_vld = br_taken;
    end else begin : g_tid_part
      assign w_br_vld = br_taken && (int'(br_tid) < N_THREADS);
    end
  endgenerate

  assign w_elig = thread_en & ~thread_block;

  // Pick stage: scan rr_ptr+1 .. rr_ptr+N, first eligible thread wins.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_idx     = '0;
    w_pick_pc = '0;
    for (int k = 1; k <= N_THREADS; k++) begin
      w_idx = TID_W'((int'(r_rr_ptr) + k) % N_THREADS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    for (int i = 0; i < N_THREADS; i++) begin
      if (w_pick == TID_W'(i)) w_pick_pc = r_pc_p0[i];
    end
  end

  assign w_take   = !fetch_stall && w_found;
  assign w_bypass = w_take && w_br_vld && (br_tid == w_pick);

  // Fetch stage: register the picked PC and advance the PC file.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_THREADS; i++) r_pc_p0[i] <= reset_pc(i);
      r_pcf_p1  <= '0;
      r_tidf_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_rr_ptr  <= TID_W'(N_THREADS - 1);
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (w_take && w_pick == TID_W'(i)) begin
          r_pc_p0[i] <= (w_bypass ? br_addr : r_pc_p0[i]) + PC_STEP;
        end else if (w_br_vld && br_tid == TID_W'(i)) begin
          r_pc_p0[i] <= br_addr;
        end
      end
      if (!fetch_stall) begin
        r_vld_p1 <= w_found;
        if (w_found) begin
          r_pcf_p1  <= w_bypass ? br_addr : w_pick_pc;
          r_tidf_p1 <= w_pick;
          r_rr_ptr  <= w_pick;
        end
      end
    end
  end

  always_comb begin
    pc_t = '0;
    for (int i = 0; i < N_THREADS; i++) pc_t[i*PC_WIDTH +: PC_WIDTH] = r_pc_p0[i];
  end

  assign pcf         = r_pcf_p1;
  assign tidf        = r_tidf_p1;
  assign fetch_valid = r_vld_p1;

endmodule

// File: tb/tb_fgmt_fetch_scheduler.sv
// Directed bench for fgmt_fetch_scheduler with hand-computed expected PCs and thread ids.
module tb_fgmt_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  thread_en;
  logic [3:0]  thread_block;
  logic        fetch_stall;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [1:0]  br_tid;
  logic [31:0] pcf;
  logic [1:0]  tidf;
  logic        fetch_valid;
  logic [127:0] pc_t;

  int total = 0;
  int bad   = 0;

  fgmt_fetch_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .thread_en    (thread_en),
    .thread_block (thread_block),
    .fetch_stall  (fetch_stall),
    .br_taken     (br_taken),
    .br_addr      (br_addr),
    .br_tid       (br_tid),
    .pcf          (pcf),
    .tidf         (tidf),
    .fetch_valid  (fetch_valid),
    .pc_t         (pc_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc(input int i);
    return pc_t[i*32 +: 32];
  endfunction

  task automatic fetch_chk(input string tag, input logic [1:0] t, input logic [31:0] p);
    check({tag, "_vld"}, 64'(fetch_valid), 64'd1);
    check({tag, "_tid"}, 64'(tidf), 64'(t));
    check({tag, "_pcf"}, 64'(pcf), 64'(p));
  endtask

  logic [1:0]  exp_tid [5];
  logic [31:0] exp_pc  [5];

  initial begin
    reset = 1'b1; thread_en = 4'hF; thread_block = 4'h0; fetch_stall = 1'b0;
    br_taken = 1'b0; br_addr = '0; br_tid = '0;
    step(); step();
    check("rst_vld", 64'(fetch_valid), 64'd0);
    check("rst_pcf", 64'(pcf), 64'd0);
    check("rst_tid", 64'(tidf), 64'd0);
    check("rst_pc1", 64'(pc(1)), 64'h100);
    check("rst_pc3", 64'(pc(3)), 64'h300);

    // round robin, all enabled
    reset = 1'b0;
    exp_tid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_pc  = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h004};
    for (int i = 0; i < 5; i++) begin
      step();
      fetch_chk($sformatf("rr%0d", i), exp_tid[i], exp_pc[i]);
    end
    check("rr_pc0", 64'(pc(0)), 64'h8);

    // only threads 0 and 2 enabled
    thread_en = 4'b0101;
    exp_tid = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    exp_pc  = '{32'h204, 32'h008, 32'h208, 32'h00C, 32'h0};
    for (int i = 0; i < 4; i++) begin
      step();
      fetch_chk($sformatf("en%0d", i), exp_tid[i], exp_pc[i]);
    end
    check("en_pc1", 64'(pc(1)), 64'h104);
    check("en_pc3", 64'(pc(3)), 64'h304);

    // redirect thread 0 while thread 2 is fetched
    br_taken = 1'b1; br_tid = 2'd0; br_addr = 32'd40;
    step();
    fetch_chk("rd_a", 2'd2, 32'h20C);
    check("rd_pc0", 64'(pc(0)), 64'd40);
    br_taken = 1'b0;
    step();
    fetch_chk("rd_b", 2'd0, 32'd40);
    check("rd_pc0b", 64'(pc(0)), 64'd44);

    // bypass onto the picked thread
    thread_en = 4'hF;
    br_taken = 1'b1; br_tid = 2'd1; br_addr = 32'h80;
    step();
    fetch_chk("byp", 2'd1, 32'h80);
    check("byp_pc1", 64'(pc(1)), 64'h84);
    br_taken = 1'b0;

    // three-cycle stall with a redirect to thread 3 in the middle
    fetch_stall = 1'b1;
    step();
    fetch_chk("st0", 2'd1, 32'h80);
    br_taken = 1'b1; br_tid = 2'd3; br_addr = 32'h500;
    step();
    fetch_chk("st1", 2'd1, 32'h80);
    check("st_pc3", 64'(pc(3)), 64'h500);
    br_taken = 1'b0;
    step();
    fetch_chk("st2", 2'd1, 32'h80);
    check("st_pc1", 64'(pc(1)), 64'h84);
    fetch_stall = 1'b0;
    step();
    fetch_chk("st_res2", 2'd2, 32'h210);
    step();
    fetch_chk("st_res3", 2'd3, 32'h500);
    check("st_pc3b", 64'(pc(3)), 64'h504);

    // nothing eligible, redirect still lands; then wrap-around on thread 0
    thread_block = 4'hF;
    br_taken = 1'b1; br_tid = 2'd0; br_addr = 32'hFFFF_FFFC;
    step();
    check("blk_vld", 64'(fetch_valid), 64'd0);
    check("blk_pcf", 64'(pcf), 64'h500);
    check("blk_tid", 64'(tidf), 64'd3);
    check("blk_pc0", 64'(pc(0)), 64'hFFFF_FFFC);
    br_taken = 1'b0; thread_block = 4'h0;
    step();
    fetch_chk("wrap", 2'd0, 32'hFFFF_FFFC);
    check("wrap_pc0", 64'(pc(0)), 64'h0);

    // single eligible thread is fetched back to back
    thread_en = 4'b0010;
    step();
    fetch_chk("one_a", 2'd1, 32'h84);
    step();
    fetch_chk("one_b", 2'd1, 32'h88);

    // mid-run reset overrides stall and redirect
    thread_en = 4'hF;
    reset = 1'b1; fetch_stall = 1'b1;
    br_taken = 1'b1; br_tid = 2'd2; br_addr = 32'h1234;
    step();
    check("mrst_vld", 64'(fetch_valid), 64'd0);
    check("mrst_pcf", 64'(pcf), 64'd0);
    check("mrst_tid", 64'(tidf), 64'd0);
    check("mrst_pc0", 64'(pc(0)), 64'h0);
    check("mrst_pc1", 64'(pc(1)), 64'h100);
    check("mrst_pc2", 64'(pc(2)), 64'h200);
    reset = 1'b0; fetch_stall = 1'b0; br_taken = 1'b0;
    step();
    fetch_chk("mrst_first", 2'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
